// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: read owner, FSM state, command direction.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD} owner_e;
    typedef enum logic {ARB_IDLE, ARB_RD_PEND} arb_state_e;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    // One-hot grant vector bit positions
    localparam int G_FE = 0;
    localparam int G_LD = 1;
    localparam int G_ST = 2;
    localparam int CNT_W = 4;

    typedef logic [2:0] gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signals of the arbiter. mem_ready exists only with MEM_ARB_WAIT_EN.
interface mem_port_arbiter_if #(parameter int AW = 32);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [3:0]    ld_byte_en;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [31:0]   ld_rdata;
    logic          st_req;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_wdata;
    logic [3:0]    st_byte_en;
    logic          st_gnt;
    logic          mem_en;
    logic          mem_rw_mode;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_read_data;
    logic          stall_pc;
`ifdef MEM_ARB_WAIT_EN
    logic          mem_ready;
`endif

    // master: the arbiter itself; slave: requesters plus memory macro
    modport master (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_byte_en,
               st_req, st_addr, st_wdata, st_byte_en, mem_read_data,
`ifdef MEM_ARB_WAIT_EN
               mem_ready,
`endif
        output fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
               st_gnt, mem_en, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en,
               stall_pc
    );

    modport slave (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_byte_en,
               st_req, st_addr, st_wdata, st_byte_en, mem_read_data,
`ifdef MEM_ARB_WAIT_EN
               mem_ready,
`endif
        input  fetch_gnt, fetch_rvalid, fetch_rdata, ld_gnt, ld_rvalid, ld_rdata,
               st_gnt, mem_en, mem_rw_mode, mem_addr, mem_write_data, mem_byte_en,
               stall_pc
    );
endinterface

// File: rtl/mem_port_arbiter_arb_prio_pick.sv
// Fixed priority st > ld > fetch, with fetch promoted to the top once it has starved STARVE_LIMIT grants.
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             en,
    input  logic             st_req,
    input  logic             ld_req,
    input  logic             fetch_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output gnt_t             pick
);
    always_comb begin
        pick = '0;
        if (en) begin
            if (fetch_req && starve_cnt == CNT_W'(STARVE_LIMIT)) pick[G_FE] = 1'b1;
            else if (st_req)                                     pick[G_ST] = 1'b1;
            else if (ld_req)                                     pick[G_LD] = 1'b1;
            else if (fetch_req)                                  pick[G_FE] = 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between fetch, load and store; routes the single outstanding read.
// Optional MEM_ARB_WAIT_EN adds mem_ready back-pressure with a frozen winner while stalled.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_port_arbiter_if.master bus
);
    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt, starve_d;
    gnt_t             pick, win, gnt;
    logic             accept;
    logic [AW-1:0]    cmd_addr;

    // Reset also masks the combinational grant path so outputs read as idle during reset
    arb_prio_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .en         (i_rst),
        .st_req     (bus.st_req),
        .ld_req     (bus.ld_req),
        .fetch_req  (bus.fetch_req),
        .starve_cnt (starve_cnt),
        .pick       (pick)
    );

`ifdef MEM_ARB_WAIT_EN
    logic hold_q;
    gnt_t hold_gnt_q;

    assign accept = bus.mem_ready;
    assign win    = hold_q ? hold_gnt_q : pick;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_q     <= 1'b0;
            hold_gnt_q <= '0;
        end else begin
            hold_q     <= (|win) && !accept;
            hold_gnt_q <= win;
        end
    end
`else
    assign accept = 1'b1;
    assign win    = pick;
`endif

    assign gnt = accept ? win : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_cnt <= starve_d;
        end
    end

    always_comb begin
        state_d  = ARB_IDLE;
        owner_d  = OWN_NONE;
        starve_d = starve_cnt;
        if (gnt[G_LD]) begin
            state_d = ARB_RD_PEND;
            owner_d = OWN_LD;
        end else if (gnt[G_FE]) begin
            state_d = ARB_RD_PEND;
            owner_d = OWN_FETCH;
        end
        if (!bus.fetch_req || gnt[G_FE])
            starve_d = '0;
        else if ((gnt[G_ST] || gnt[G_LD]) && starve_cnt != '1)
            starve_d = starve_cnt + 1'b1;
    end

    always_comb begin
        bus.mem_en         = 1'b0;
        bus.mem_rw_mode    = MEM_RD;
        cmd_addr           = '0;
        bus.mem_write_data = '0;
        bus.mem_byte_en    = '0;
        if (win[G_ST]) begin
            bus.mem_en         = 1'b1;
            bus.mem_rw_mode    = MEM_WR;
            cmd_addr           = bus.st_addr;
            bus.mem_write_data = bus.st_wdata;
            bus.mem_byte_en    = bus.st_byte_en;
        end else if (win[G_LD]) begin
            bus.mem_en      = 1'b1;
            cmd_addr        = bus.ld_addr;
            bus.mem_byte_en = bus.ld_byte_en;
        end else if (win[G_FE]) begin
            bus.mem_en      = 1'b1;
            cmd_addr        = bus.fetch_addr;
            bus.mem_byte_en = 4'b1111;
        end
    end

    assign bus.mem_addr     = cmd_addr;
    assign bus.st_gnt       = gnt[G_ST];
    assign bus.ld_gnt       = gnt[G_LD];
    assign bus.fetch_gnt    = gnt[G_FE];
    assign bus.stall_pc     = i_rst && bus.fetch_req && !gnt[G_FE];
    assign bus.fetch_rvalid = (state_q == ARB_RD_PEND) && (owner_q == OWN_FETCH);
    assign bus.ld_rvalid    = (state_q == ARB_RD_PEND) && (owner_q == OWN_LD);
    assign bus.fetch_rdata  = bus.fetch_rvalid ? bus.mem_read_data : 32'h0;
    assign bus.ld_rdata     = bus.ld_rvalid ? bus.mem_read_data : 32'h0;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between three requesters: instruction fetch, load unit and store unit.
- Fixed-priority arbitration (store > load > fetch) with a fetch-starvation guard.
- Tracks the one outstanding read and routes returned data to its owner.
- Drives pc stall while fetch waits; sits between the execute-stage memory units and the memory macro.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants that may pass a waiting fetch before fetch is forced to highest priority (1..15).
- AW, 32, address width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch read request, held until granted
- fetch_addr  in  AW  fetch word address
- fetch_gnt  out  1  fetch command issued this cycle
- fetch_rvalid  out  1  fetch read data valid
- fetch_rdata  out  32  fetch read data
- ld_req  in  1  load read request, held until granted
- ld_addr  in  AW  load address
- ld_byte_en  in  4  load byte lanes
- ld_gnt  out  1  load command issued
- ld_rvalid  out  1  load data valid
- ld_rdata  out  32  load data, raw word
- st_req  in  1  store request, held until granted
- st_addr  in  AW  store address
- st_wdata  in  32  lane-aligned write data
- st_byte_en  in  4  store byte lanes
- st_gnt  out  1  store command issued (write completes this cycle)
- mem_en  out  1  memory command valid
- mem_rw_mode  out  1  1 = read, 0 = write
- mem_addr  out  AW  memory address
- mem_write_data  out  32  memory write data
- mem_byte_en  out  4  memory byte enables
- mem_read_data  in  32  memory read data, valid one cycle after a read command
- stall_pc  out  1  fetch_req high and fetch_gnt low

Behaviour:
- Reset: every output 0 except mem_rw_mode = 1. State IDLE, starve_cnt = 0.
- Grant decision and gnt outputs are combinational in the request cycle. At most one gnt per cycle. Commands are driven on mem_* in the same cycle as gnt.
- When no grant is issued: mem_en = 0, mem_rw_mode = 1, mem_addr/mem_write_data/mem_byte_en = 0.
- Priority: st > ld > fetch. If starve_cnt == STARVE_LIMIT and fetch_req is high, fetch wins.
- starve_cnt:
  - increments, saturating, on each st/ld grant while fetch_req is high;
  - clears on a fetch grant or whenever fetch_req is low.
- Fetch commands use mem_byte_en = 4'b1111. Load commands use ld_byte_en.
- FSM states: IDLE, RD_PEND.
  - A read grant sets owner (FETCH/LD) and moves to RD_PEND.
  - In RD_PEND: the owner's rvalid = 1 and rdata = mem_read_data. In the same cycle a new grant may issue, giving one access per cycle throughput.
  - RD_PEND → IDLE when no new read is granted.
- A write grant does not enter RD_PEND.
- Non-owner rvalid is always 0. Non-owner rdata is held at 0.
- Simultaneous st_req, ld_req and fetch_req: st granted; ld next cycle; fetch after that, unless the starvation guard fires.
- Reset mid-RD_PEND: pending read dropped, no rvalid issued after reset release.

Optional Feature:
- Macro MEM_ARB_WAIT_EN.
- Defined:
  - Adds input mem_ready (1 bit).
  - A command completes only in a cycle with mem_ready = 1. While mem_en = 1 and mem_ready = 0, mem_* are held stable, no gnt is asserted, and the arbitration winner is frozen.
  - gnt asserts in the cycle the command is accepted.
  - Read data is still valid the cycle after acceptance.
- Undefined: memory is always ready; behaviour as above.

Decomposition:
- Shared package holds:
  - typedef enum owner_e {OWN_NONE, OWN_FETCH, OWN_LD};
  - typedef enum arb_state_e {ARB_IDLE, ARB_RD_PEND};
  - constants MEM_RD = 1'b1 and MEM_WR = 1'b0.
- One sub-module is natural: arb_prio_pick (combinational priority plus starvation override, returning a one-hot grant).

Test Plan:
- st_req only: addr 0x100, wdata 0xA5A5A5A5, be 4'b1111 → st_gnt=1, mem_en=1, mem_rw_mode=0, mem_addr=0x100 in the same cycle; no rvalid follows.
- ld_req addr 0x204, mem_read_data=0x12345678 next cycle → ld_gnt in cycle 0; ld_rvalid=1 with ld_rdata=0x12345678 in cycle 1; fetch_rvalid=0.
- st, ld and fetch requested together and held → grants st (c0), ld (c1), fetch (c2); stall_pc=1 for c0–c1 and 0 at c2.
- fetch_req held while ld_req is continuously re-asserted, STARVE_LIMIT=4 → 4 ld grants, then fetch_gnt on the 5th cycle, and starve_cnt returns to 0.
- Back-to-back fetch reads to 0x0, 0x4, 0x8 → one gnt per cycle; fetch_rvalid high for 3 consecutive cycles with the matching data.
- i_rst low in the cycle after a load grant → all outputs at reset values, ld_rvalid never asserted; with MEM_ARB_WAIT_EN and mem_ready=0 for 2 cycles, mem_addr holds and gnt is delayed 2 cycles.
